// File: rtl/cmd_mem_responder.sv
// Command-memory server for one sequencer core: pipelined instr_ptr reads from a
// dual-port command RAM, plus a host path that stages 32-bit lanes into full words.
module cmd_mem_responder #(
  parameter int unsigned CMD_WIDTH            = 128,
  parameter int unsigned CMD_ADDR_WIDTH       = 8,
  parameter int unsigned HOST_WIDTH           = 32,
  parameter int unsigned CMD_MEM_READ_LATENCY = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [CMD_ADDR_WIDTH-1:0] instr_ptr,
  output logic [CMD_WIDTH-1:0]      cmd_read,
  output logic                      cmd_valid,
  input  logic                      host_we,
  input  logic [CMD_ADDR_WIDTH+1:0] host_addr,
  input  logic [HOST_WIDTH-1:0]     host_wdata,
  input  logic                      lock,
  output logic [3:0]                stage_mask,
  output logic                      commit,
  output logic                      seq_err,
  output logic [7:0]                drop_cnt
);

  localparam int unsigned LANES = 4;
  localparam int unsigned DEPTH = 1 << CMD_ADDR_WIDTH;
  localparam int unsigned LAT   = CMD_MEM_READ_LATENCY;

  logic [CMD_WIDTH-1:0]      mem [DEPTH];
  logic [CMD_WIDTH-1:0]      rd_pipe [LAT];
  logic [LAT-1:0]            vld_pipe;

  logic [CMD_ADDR_WIDTH-1:0] stage_addr;
  logic [CMD_WIDTH-1:0]      stage_data;

  logic [CMD_ADDR_WIDTH-1:0] host_word;
  logic [1:0]                host_lane;
  logic                      host_hit;
  logic                      addr_change;
  logic [3:0]                mask_nx;
  logic [CMD_WIDTH-1:0]      data_nx;
  logic                      do_commit;

  assign host_word = host_addr[CMD_ADDR_WIDTH+1:2];
  assign host_lane = host_addr[1:0];

  // Next staging contents if the current host write is accepted.
  always_comb begin
    host_hit    = host_we & ~lock;
    addr_change = (stage_mask != 4'b0000) && (host_word != stage_addr);
    mask_nx     = ((stage_mask == 4'b0000) || addr_change) ? 4'b0000 : stage_mask;
    mask_nx     = mask_nx | (4'b0001 << host_lane);
    data_nx     = stage_data;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (host_lane == 2'(i)) begin
        data_nx[i*HOST_WIDTH +: HOST_WIDTH] = host_wdata;
      end
    end
    do_commit   = host_hit && (mask_nx == 4'b1111) && !reset;
  end

  // Command RAM write port; a read on the same edge sees the old word.
  always_ff @(posedge clk) begin
    if (do_commit) begin
      mem[host_word] <= data_nx;
    end
  end

  // Read data pipeline and parallel valid shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        rd_pipe[i] <= '0;
      end
      vld_pipe <= '0;
    end else begin
      rd_pipe[0] <= mem[instr_ptr];
      for (int unsigned i = 1; i < LAT; i++) begin
        rd_pipe[i] <= rd_pipe[i-1];
      end
      vld_pipe <= (vld_pipe << 1) | LAT'(1);
    end
  end

  assign cmd_read  = rd_pipe[LAT-1];
  assign cmd_valid = vld_pipe[LAT-1];

  // Host staging, commit pulse and error/drop bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stage_addr <= '0;
      stage_data <= '0;
      stage_mask <= 4'b0000;
      commit     <= 1'b0;
      seq_err    <= 1'b0;
      drop_cnt   <= 8'd0;
    end else begin
      commit <= do_commit;
      if (host_hit) begin
        stage_addr <= host_word;
        stage_data <= data_nx;
        stage_mask <= do_commit ? 4'b0000 : mask_nx;
        if (addr_change) begin
          seq_err <= 1'b1;
        end
      end else if (host_we && lock && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_mem_responder.sv
// Self-checking bench for cmd_mem_responder: reference model of the staging path
// and RAM, with a scoreboard queue of expected read words.
module tb_cmd_mem_responder;

  localparam int unsigned LAT = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [7:0]   instr_ptr = 8'd0;
  logic [127:0] cmd_read;
  logic         cmd_valid;
  logic         host_we = 1'b0;
  logic [9:0]   host_addr = 10'd0;
  logic [31:0]  host_wdata = 32'd0;
  logic         lock = 1'b0;
  logic [3:0]   stage_mask;
  logic         commit;
  logic         seq_err;
  logic [7:0]   drop_cnt;

  cmd_mem_responder #(
    .CMD_WIDTH(128), .CMD_ADDR_WIDTH(8), .HOST_WIDTH(32), .CMD_MEM_READ_LATENCY(LAT)
  ) dut (
    .clk(clk), .reset(reset), .instr_ptr(instr_ptr), .cmd_read(cmd_read),
    .cmd_valid(cmd_valid), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .lock(lock), .stage_mask(stage_mask),
    .commit(commit), .seq_err(seq_err), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [127:0] mmem [256];
  logic [127:0] sbq [$];
  logic [3:0]   m_mask;
  logic [7:0]   m_addr;
  logic [127:0] m_data;
  logic         m_seq;
  logic [7:0]   m_drop;
  logic         m_commit;
  int           edge_cnt;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mask   = 4'b0000;
    m_addr   = 8'd0;
    m_data   = '0;
    m_seq    = 1'b0;
    m_drop   = 8'd0;
    m_commit = 1'b0;
    edge_cnt = 0;
    sbq.delete();
  endtask

  // Drive one cycle of stimulus, advance the model, then check after the edge.
  task automatic step(input logic we, input logic [7:0] w, input logic [1:0] ln,
                      input logic [31:0] d, input logic lk, input logic [7:0] p);
    host_we    = we;
    host_addr  = {w, ln};
    host_wdata = d;
    lock       = lk;
    instr_ptr  = p;
    sbq.push_back(mmem[p]);
    m_commit = 1'b0;
    if (we && !lk) begin
      if (m_mask != 4'b0000 && w != m_addr) m_seq = 1'b1;
      if (m_mask == 4'b0000 || w != m_addr) begin
        m_mask = 4'b0000;
        m_addr = w;
      end
      m_data[int'(ln)*32 +: 32] = d;
      m_mask[ln] = 1'b1;
      if (m_mask == 4'b1111) begin
        mmem[w]  = m_data;
        m_commit = 1'b1;
        m_mask   = 4'b0000;
      end
    end else if (we && lk && m_drop != 8'hFF) begin
      m_drop = m_drop + 8'd1;
    end
    @(posedge clk);
    #1;
    edge_cnt++;
    check("stage_mask", 128'(stage_mask), 128'(m_mask));
    check("commit", 128'(commit), 128'(m_commit));
    check("seq_err", 128'(seq_err), 128'(m_seq));
    check("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    if (edge_cnt >= int'(LAT)) begin
      check("cmd_valid", 128'(cmd_valid), 128'(1));
      check("sb_nonempty", 128'(sbq.size() != 0), 128'(1));
      if (sbq.size() != 0) check("cmd_read", cmd_read, sbq.pop_front());
    end else begin
      check("cmd_valid_pre", 128'(cmd_valid), 128'(0));
      check("cmd_read_pre", cmd_read, 128'(0));
    end
  endtask

  task automatic idle(input int n, input logic [7:0] p);
    for (int i = 0; i < n; i++) step(1'b0, 8'd0, 2'd0, 32'd0, 1'b0, p);
  endtask

  task automatic wr(input logic [7:0] w, input logic [1:0] ln, input logic [31:0] d);
    step(1'b1, w, ln, d, 1'b0, 8'd0);
  endtask

  task automatic do_reset();
    host_we = 1'b0;
    lock    = 1'b0;
    reset   = 1'b1;
    #1;
    check("rst_stage_mask", 128'(stage_mask), 128'(0));
    check("rst_cmd_valid", 128'(cmd_valid), 128'(0));
    check("rst_commit", 128'(commit), 128'(0));
    check("rst_cmd_read", cmd_read, 128'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mmem[i] = '0;
    model_reset();
    #2;
    do_reset();

    // Valid ramp with instr_ptr held at 0.
    idle(6, 8'd0);

    // Full word 5, then read it back.
    wr(8'd5, 2'd0, 32'h11111111);
    wr(8'd5, 2'd1, 32'h22222222);
    wr(8'd5, 2'd2, 32'h33333333);
    wr(8'd5, 2'd3, 32'h44444444);
    idle(1, 8'd5);
    idle(4, 8'd0);

    // Address change mid-stage aborts word 7.
    wr(8'd7, 2'd0, 32'h77770000);
    wr(8'd7, 2'd1, 32'h77771111);
    wr(8'd8, 2'd2, 32'h88882222);
    wr(8'd8, 2'd2, 32'h8888AAAA);
    wr(8'd8, 2'd0, 32'h88880000);
    wr(8'd8, 2'd1, 32'h88881111);
    wr(8'd8, 2'd3, 32'h88883333);
    idle(1, 8'd7);
    idle(1, 8'd8);
    idle(4, 8'd0);

    // Partial stage survives a locked burst of 300 dropped writes.
    wr(8'd11, 2'd0, 32'hB0B0B0B0);
    wr(8'd11, 2'd1, 32'hB1B1B1B1);
    for (int i = 0; i < 300; i++)
      step(1'b1, (i % 2 == 0) ? 8'd10 : 8'd11, 2'(i), $urandom, 1'b1, 8'(i));
    wr(8'd11, 2'd2, 32'hB2B2B2B2);
    wr(8'd11, 2'd3, 32'hB3B3B3B3);
    idle(1, 8'd10);
    idle(1, 8'd11);
    idle(4, 8'd0);

    // Read-first collision on word 9.
    wr(8'd9, 2'd0, 32'hAAAAAAAA);
    wr(8'd9, 2'd1, 32'hAAAAAAAA);
    wr(8'd9, 2'd2, 32'hAAAAAAAA);
    step(1'b1, 8'd9, 2'd3, 32'hAAAAAAAA, 1'b0, 8'd9);
    idle(1, 8'd9);
    idle(4, 8'd0);

    // Back-to-back streaming reads.
    for (int i = 0; i < 4; i++) idle(1, 8'(i));
    for (int i = 4; i < 12; i++) idle(1, 8'(i));
    idle(4, 8'd0);

    // Reset mid-stage discards the partial word.
    wr(8'd12, 2'd0, 32'hC0C0C0C0);
    wr(8'd12, 2'd1, 32'hC1C1C1C1);
    do_reset();
    idle(2, 8'd12);
    idle(6, 8'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
